// File: rtl/logic_capture_rle_pkg.sv
// ---------------------------------------------------------------------------
// logic_capture_rle_pkg
// Shared definitions for the run-length encoding capture stage:
//   - capture sequencer state encodings
//   - packed word field positions (value [31:16], run length minus 1 [15:0])
//   - saturation limit of the 16-bit run counter
//   - packRun helper that builds a {value, count} word
// ---------------------------------------------------------------------------
package logic_capture_rle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } capState_e;

    localparam int VALUE_MSB = 31;
    localparam int VALUE_LSB = 16;
    localparam int COUNT_MSB = 15;
    localparam int COUNT_LSB = 0;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    // Build an output word from a run value and its length-minus-one count.
    function automatic logic [31:0] packRun(input logic [15:0] value,
                                            input logic [15:0] count);
        logic [31:0] word;
        word = '0;
        word[VALUE_MSB:VALUE_LSB] = value;
        word[COUNT_MSB:COUNT_LSB] = count;
        return word;
    endfunction

endpackage

// File: rtl/logic_capture_rle_enc.sv
// ---------------------------------------------------------------------------
// logic_capture_rle_enc
// Holds the currently open run (value + length-minus-one count) and flags
// when an incoming sample closes that run.
//
// Ports:
//   clk_i          capture clock
//   rst_i          asynchronous active-high reset
//   open_i         start a fresh run from sample_i with count 0 (trigger)
//   capture_i      sequencer is in CAPTURE; samples extend/close the run
//   sample_i       16-channel sample
//   sample_valid_i sample strobe
//   close_o        this sample closes the open run (combinational strobe)
//   run_word_o     {value, count} of the open run as held now
// ---------------------------------------------------------------------------
module logic_capture_rle_enc
    import logic_capture_rle_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        open_i,
    input  logic        capture_i,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i,
    output logic        close_o,
    output logic [31:0] run_word_o
);

    logic [15:0] runValue_q;
    logic [15:0] runCount_q;
    logic [15:0] runValue_d;
    logic [15:0] runCount_d;
    logic        closeRun;

    // A saturated counter closes the run even when the value is unchanged,
    // so a long constant stretch continues as a new word with the same value.
    assign closeRun = capture_i && sample_valid_i &&
                      ((sample_i != runValue_q) || (runCount_q == COUNT_MAX));

    // Next run contents: restart on trigger or close, otherwise extend.
    always_comb begin
        runValue_d = runValue_q;
        runCount_d = runCount_q;
        if (open_i || closeRun) begin
            runValue_d = sample_i;
            runCount_d = 16'd0;
        end else if (capture_i && sample_valid_i) begin
            runCount_d = runCount_q + 16'd1;
        end
    end

    // Run registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            runValue_q <= 16'd0;
            runCount_q <= 16'd0;
        end else begin
            runValue_q <= runValue_d;
            runCount_q <= runCount_d;
        end
    end

    assign close_o    = closeRun;
    assign run_word_o = packRun(runValue_q, runCount_q);

endmodule

// File: rtl/logic_capture_rle.sv
// ---------------------------------------------------------------------------
// logic_capture_rle
// Capture sequencer in front of the capture FIFO: arms, waits for a masked
// trigger, run-length encodes the sample stream into {value, count} words and
// pushes them into the FIFO through a single-entry output register.
//
// Ports:
//   clk_i / rst_i   clock, asynchronous active-high reset
//   start_i         arm a capture from IDLE or DONE
//   abort_i         stop the capture, flushing any open run
//   length_i        word limit latched on start (0 = unlimited)
//   trig_mask_i     trigger channel mask (0 = immediate trigger)
//   trig_value_i    trigger match value
//   sample_i        channel sample, qualified by sample_valid_i
//   accept_i        FIFO can take a word this cycle
//   data_o / push_o output word and its valid (held until accepted)
//   busy_o          ARMED, CAPTURE or FLUSH
//   triggered_o     trigger seen in this capture
//   done_o          capture finished
//   overflow_o      sticky: a closed run was dropped
//   words_o         words accepted by the FIFO in this capture
// ---------------------------------------------------------------------------
module logic_capture_rle
    import logic_capture_rle_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] length_i,
    input  logic [15:0] trig_mask_i,
    input  logic [15:0] trig_value_i,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i,
    input  logic        accept_i,
    output logic [31:0] data_o,
    output logic        push_o,
    output logic        busy_o,
    output logic        triggered_o,
    output logic        done_o,
    output logic        overflow_o,
    output logic [31:0] words_o
);

    capState_e   state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        push_q, push_d;
    logic [31:0] words_q, words_d;
    logic        overflow_q, overflow_d;
    logic        triggered_q, triggered_d;
    logic [31:0] length_q, length_d;
    logic        flushLoaded_q, flushLoaded_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        openRun;
    logic        runClose;
    logic [31:0] runWord;
    logic        trigMatch;
    logic        acceptFire;
    logic        lastWord;

    logic_capture_rle_enc u_enc (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .open_i         (openRun),
        .capture_i      (state_q == ST_CAPTURE),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .close_o        (runClose),
        .run_word_o     (runWord)
    );

    assign trigMatch  = ((sample_i ^ trig_value_i) & trig_mask_i) == 16'd0;
    assign acceptFire = push_q && accept_i;
    // The accept that reaches the latched limit ends the capture at once.
    assign lastWord   = acceptFire && (length_q != 32'd0) &&
                        ((words_q + 32'd1) == length_q);

    // Next-state logic for the sequencer, output register and counters.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        push_d        = push_q;
        words_d       = words_q;
        overflow_d    = overflow_q;
        triggered_d   = triggered_q;
        length_d      = length_q;
        flushLoaded_d = flushLoaded_q;
        openRun       = 1'b0;

        if (acceptFire) begin
            words_d = words_q + 32'd1;
            push_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i && !abort_i) begin
                    state_d       = ST_ARMED;
                    words_d       = 32'd0;
                    overflow_d    = 1'b0;
                    triggered_d   = 1'b0;
                    length_d      = length_i;
                    flushLoaded_d = 1'b0;
                    push_d        = 1'b0;
                end
            end
            ST_ARMED: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (sample_valid_i && trigMatch) begin
                    state_d     = ST_CAPTURE;
                    triggered_d = 1'b1;
                    openRun     = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (lastWord) begin
                    state_d = ST_DONE;
                end else begin
                    // A closed run loads only if the register is free or is
                    // being emptied this very cycle; otherwise it is lost.
                    if (runClose) begin
                        if (!push_q || accept_i) begin
                            data_d = runWord;
                            push_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (abort_i) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (lastWord || (acceptFire && flushLoaded_q)) begin
                    state_d = ST_DONE;
                end else if (!push_q && !flushLoaded_q) begin
                    data_d        = runWord;
                    push_d        = 1'b1;
                    flushLoaded_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE) ||
                    (state_d == ST_FLUSH);
    assign done_d = (state_d == ST_DONE);

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            data_q        <= 32'd0;
            push_q        <= 1'b0;
            words_q       <= 32'd0;
            overflow_q    <= 1'b0;
            triggered_q   <= 1'b0;
            length_q      <= 32'd0;
            flushLoaded_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            push_q        <= push_d;
            words_q       <= words_d;
            overflow_q    <= overflow_d;
            triggered_q   <= triggered_d;
            length_q      <= length_d;
            flushLoaded_q <= flushLoaded_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign data_o      = data_q;
    assign push_o      = push_q;
    assign busy_o      = busy_q;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
    assign words_o     = words_q;

endmodule

// File: tb/tb_logic_capture_rle.sv
// ---------------------------------------------------------------------------
// tb_logic_capture_rle
// Self-checking bench for logic_capture_rle: a per-cycle vector table for a
// basic capture, then hand-written sequences for trigger masking, counter
// saturation, length limit, overflow and mid-capture reset.
// ---------------------------------------------------------------------------
module tb_logic_capture_rle;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] length;
    logic [15:0] trigMask;
    logic [15:0] trigValue;
    logic [15:0] sample;
    logic        sampleValid;
    logic        accept;
    logic [31:0] dataOut;
    logic        push;
    logic        busy;
    logic        triggered;
    logic        done;
    logic        overflow;
    logic [31:0] words;

    int checks   = 0;
    int failures = 0;

    logic [31:0] gotWords[$];
    logic [31:0] expWords[$];

    typedef struct {
        logic        start;
        logic        abort;
        logic [15:0] sample;
        logic        valid;
        logic        accept;
        logic        expPush;
        logic [31:0] expData;
        logic [31:0] expWords;
        logic        expBusy;
        logic        expDone;
        logic        expTrig;
    } vec_t;

    vec_t vecs[8];

    logic_capture_rle dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .abort_i        (abort),
        .length_i       (length),
        .trig_mask_i    (trigMask),
        .trig_value_i   (trigValue),
        .sample_i       (sample),
        .sample_valid_i (sampleValid),
        .accept_i       (accept),
        .data_o         (dataOut),
        .push_o         (push),
        .busy_o         (busy),
        .triggered_o    (triggered),
        .done_o         (done),
        .overflow_o     (overflow),
        .words_o        (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every word the FIFO takes; inputs are stable mid-cycle.
    always @(negedge clk) begin
        if (push && accept) gotWords.push_back(dataOut);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ab,
                                 input logic [15:0] smp, input logic vld,
                                 input logic acc);
        start       = st;
        abort       = ab;
        sample      = smp;
        sampleValid = vld;
        accept      = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkWords(input string name);
        checkOutput({name, "_count"}, gotWords.size(), expWords.size());
        for (int i = 0; i < gotWords.size() && i < expWords.size(); i++)
            checkOutput($sformatf("%s_word%0d", name, i), gotWords[i], expWords[i]);
    endtask

    task automatic waitDone(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles && !done; i++)
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput({name, "_done"}, done, 1'b1);
    endtask

    task automatic newCapture(input logic [31:0] len, input logic [15:0] mask,
                              input logic [15:0] value, input logic acc);
        length    = len;
        trigMask  = mask;
        trigValue = value;
        gotWords.delete();
        expWords.delete();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, acc);
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; length = 0; trigMask = 0;
        trigValue = 0; sample = 0; sampleValid = 0; accept = 1;

        // Basic capture: mask 0, length 0, runs 0x0001 x3 and 0x0002 x1.
        vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b1, 32'h00010002, 32'd0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0,        32'd1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h00020000, 32'd1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0,        32'd2, 1'b0, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_data", dataOut, 32'h0);
        checkOutput("reset_push", push, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_words", words, 32'd0);
        rst = 1'b0;

        // Table-driven basic capture.
        gotWords.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].sample,
                          vecs[i].valid, vecs[i].accept);
            checkOutput($sformatf("vec%0d_push", i), push, vecs[i].expPush);
            if (vecs[i].expPush)
                checkOutput($sformatf("vec%0d_data", i), dataOut, vecs[i].expData);
            checkOutput($sformatf("vec%0d_words", i), words, vecs[i].expWords);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d_done", i), done, vecs[i].expDone);
            checkOutput($sformatf("vec%0d_trig", i), triggered, vecs[i].expTrig);
        end
        expWords.delete();
        expWords.push_back(32'h00010002);
        expWords.push_back(32'h00020000);
        checkWords("basic");

        // Masked trigger: only bit 7 set in the sample fires.
        newCapture(32'd0, 16'h0080, 16'h0080, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0010, 1'b1, 1'b1);
        checkOutput("mask_not_trig", triggered, 1'b0);
        checkOutput("mask_armed_busy", busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0090, 1'b1, 1'b1);
        checkOutput("mask_trig", triggered, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0090, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        waitDone("mask", 20);
        expWords.push_back(32'h00900001);
        checkWords("mask");
        checkOutput("mask_words", words, 32'd1);

        // Counter saturation: 65537 equal samples, then a different one.
        newCapture(32'd0, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 65537; i++)
            applyStimulus(1'b0, 1'b0, 16'h5A5A, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        waitDone("sat", 20);
        expWords.push_back(32'h5A5AFFFF);
        expWords.push_back(32'h5A5A0000);
        expWords.push_back(32'h00000000);
        checkWords("sat");
        checkOutput("sat_words", words, 32'd3);
        checkOutput("sat_overflow", overflow, 1'b0);

        // Length limit of 2 with a new value every sample.
        newCapture(32'd2, 16'h0000, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0001, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0002, 1'b1, 1'b1);
        checkOutput("len_push1", push, 1'b1);
        checkOutput("len_data1", dataOut, 32'h00010000);
        applyStimulus(1'b0, 1'b0, 16'h0001, 1'b1, 1'b1);
        checkOutput("len_data2", dataOut, 32'h00020000);
        checkOutput("len_words1", words, 32'd1);
        checkOutput("len_done_early", done, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0002, 1'b1, 1'b1);
        checkOutput("len_done", done, 1'b1);
        checkOutput("len_words2", words, 32'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, (i % 2 == 0) ? 16'h0001 : 16'h0002, 1'b1, 1'b1);
            checkOutput($sformatf("len_nopush%0d", i), push, 1'b0);
        end
        expWords.push_back(32'h00010000);
        expWords.push_back(32'h00020000);
        checkWords("len");

        // Overflow: FIFO refuses while three runs close.
        newCapture(32'd0, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0011, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0022, 1'b1, 1'b0);
        checkOutput("ovf_push", push, 1'b1);
        checkOutput("ovf_none_yet", overflow, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0033, 1'b1, 1'b0);
        checkOutput("ovf_set", overflow, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0044, 1'b1, 1'b0);
        checkOutput("ovf_data_stable", dataOut, 32'h00110000);
        checkOutput("ovf_words0", words, 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("ovf_words1", words, 32'd1);
        checkOutput("ovf_push_clear", push, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        waitDone("ovf", 20);
        expWords.push_back(32'h00110000);
        expWords.push_back(32'h00440000);
        checkWords("ovf");
        checkOutput("ovf_sticky", overflow, 1'b1);

        // Reset while a word is held in the output register.
        newCapture(32'd0, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0001, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0002, 1'b1, 1'b0);
        checkOutput("rst_pre_push", push, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst_push", push, 1'b0);
        checkOutput("rst_data", dataOut, 32'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_trig", triggered, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_words", words, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        newCapture(32'd0, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0003, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0004, 1'b1, 1'b0);
        checkOutput("rst_after_push", push, 1'b1);
        checkOutput("rst_after_data", dataOut, 32'h00030000);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        waitDone("rst_after", 20);
        checkOutput("rst_after_words", words, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
